game_sequencer: RTL and testbench

//  Sequences the two-bot game in the clk (100MHz) domain: start screen, map arm, play, respawn, win screen.

---
 rtl/game_seq_pkg.sv | 20 ++
 rtl/game_sequencer_fire.sv | 28 ++
 rtl/game_sequencer.sv | 160 ++++++++++++++++
 tb/tb_game_sequencer.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_seq_pkg.sv
// game_seq_pkg: shared state codes, one-hot frame constants and bot indices for the game sequencer.
package game_seq_pkg;
  typedef enum logic [2:0] {
    ST_START   = 3'd0,
    ST_ARM     = 3'd1,
    ST_PLAY    = 3'd2,
    ST_RESPAWN = 3'd3,
    ST_WIN     = 3'd4
  } state_e;
  localparam logic [4:0] FRAME_START = 5'b00001;
  localparam logic [4:0] FRAME_MAP1  = 5'b00010;
  localparam logic [4:0] FRAME_MAP2  = 5'b00100;
  localparam logic [4:0] FRAME_TANK  = 5'b01000;
  localparam logic [4:0] FRAME_TRAIN = 5'b10000;
  localparam int BOT_TANK  = 0;
  localparam int BOT_TRAIN = 1;
  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return s + {3'b000, s != 4'hf};
  endfunction
endpackage

// File: rtl/game_sequencer_fire.sv
// fire_cooldown: one bot's fire gate; a shot reloads an 8-bit tick cooldown that must drain before the next.
module fire_cooldown #(
  parameter int COOLDOWN_TICKS = 16
) (
  input  logic clk,
  input  logic rstn,
  input  logic req,
  input  logic tick,
  input  logic enable,
  output logic fire
);
  logic [7:0] cnt_q, cnt_d;
  logic       fire_q, fire_d;
  always_comb begin
    fire_d = enable && req && cnt_q == 8'd0;
    cnt_d  = fire_d ? 8'(COOLDOWN_TICKS) : (tick && cnt_q != 8'd0) ? cnt_q - 8'd1 : cnt_q;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q  <= '0;
      fire_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      fire_q <= fire_d;
    end
  end
  assign fire = fire_q;
endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: two-bot game FSM (start, arm, play, respawn, win) with scores, bot resets and fire gating.
// Optional round time limit enabled by defining GAME_SEQ_TIMEOUT_EN.
module game_sequencer
  import game_seq_pkg::*;
#(
  parameter int WIN_SCORE      = 3,
  parameter int COOLDOWN_TICKS = 16,
  parameter int RESPAWN_TICKS  = 32,
  parameter int WIN_HOLD_TICKS = 200,
  parameter int RST_CYCLES     = 4
`ifdef GAME_SEQ_TIMEOUT_EN
  , parameter int ROUND_TICKS  = 4000
`endif
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start_i,
  input  logic       map_sel_i,
  input  logic       tick_i,
  input  logic [1:0] fire_req_i,
  input  logic [1:0] hit_i,
  output logic [4:0] frame_o,
  output logic [1:0] bot_rst_o,
  output logic [1:0] fire_o,
  output logic [3:0] score_tank_o,
  output logic [3:0] score_train_o,
  output logic [2:0] state_o
);
  state_e     state_q, state_d;
  logic       map_q, map_d;
  logic [4:0] frame_q, frame_d;
  logic [1:0] bot_rst_q, bot_rst_d;
  logic [3:0] score_tank_q, score_tank_d, score_train_q, score_train_d;
  logic [3:0] rst_cnt_q, rst_cnt_d;
  logic [9:0] tick_cnt_q, tick_cnt_d;
  logic       single_hit;
`ifdef GAME_SEQ_TIMEOUT_EN
  logic [15:0] round_q, round_d;
  logic        in_round;
  assign in_round = state_q == ST_PLAY || state_q == ST_RESPAWN;
`endif
  assign single_hit = ^hit_i;
  always_comb begin
    state_d       = state_q;
    map_d         = map_q;
    frame_d       = frame_q;
    bot_rst_d     = bot_rst_q;
    score_tank_d  = score_tank_q;
    score_train_d = score_train_q;
    rst_cnt_d     = rst_cnt_q;
    tick_cnt_d    = tick_cnt_q;
    case (state_q)
      ST_START: if (start_i) begin
        state_d       = ST_ARM;
        map_d         = map_sel_i;
        frame_d       = map_sel_i ? FRAME_MAP2 : FRAME_MAP1;
        score_tank_d  = '0;
        score_train_d = '0;
        rst_cnt_d     = '0;
      end
      ST_ARM: if (rst_cnt_q == 4'(RST_CYCLES - 1)) begin
        state_d   = ST_PLAY;
        bot_rst_d = 2'b00;
        rst_cnt_d = '0;
      end else rst_cnt_d = rst_cnt_q + 4'd1;
      ST_PLAY: if (hit_i != 2'b00) begin
        // hit_i names the victim, so the opponent scores; a double KO scores nobody
        score_tank_d  = (single_hit && hit_i[BOT_TRAIN]) ? sat_inc(score_tank_q) : score_tank_q;
        score_train_d = (single_hit && hit_i[BOT_TANK]) ? sat_inc(score_train_q) : score_train_q;
        rst_cnt_d     = '0;
        tick_cnt_d    = '0;
        if (score_tank_d >= 4'(WIN_SCORE) || score_train_d >= 4'(WIN_SCORE)) begin
          state_d   = ST_WIN;
          frame_d   = score_tank_d >= 4'(WIN_SCORE) ? FRAME_TANK : FRAME_TRAIN;
          bot_rst_d = 2'b11;
        end else begin
          state_d   = ST_RESPAWN;
          bot_rst_d = hit_i;
        end
      end
      ST_RESPAWN: begin
        if (bot_rst_q != 2'b00) begin
          bot_rst_d = rst_cnt_q == 4'(RST_CYCLES - 1) ? 2'b00 : bot_rst_q;
          rst_cnt_d = rst_cnt_q == 4'(RST_CYCLES - 1) ? '0 : rst_cnt_q + 4'd1;
        end
        if (tick_i && tick_cnt_q == 10'(RESPAWN_TICKS - 1)) begin
          state_d    = ST_PLAY;
          bot_rst_d  = 2'b00;
          rst_cnt_d  = '0;
          tick_cnt_d = '0;
        end else if (tick_i) tick_cnt_d = tick_cnt_q + 10'd1;
      end
      ST_WIN: if (tick_i && tick_cnt_q == 10'(WIN_HOLD_TICKS - 1)) begin
        state_d    = ST_START;
        frame_d    = FRAME_START;
        tick_cnt_d = '0;
      end else if (tick_i) tick_cnt_d = tick_cnt_q + 10'd1;
      default: begin
        state_d   = ST_START;
        frame_d   = FRAME_START;
        bot_rst_d = 2'b11;
      end
    endcase
`ifdef GAME_SEQ_TIMEOUT_EN
    round_d = (state_q == ST_START || state_q == ST_ARM) ? '0 : (in_round && tick_i) ? round_q + 16'd1 : round_q;
    // time-out judges on this cycle's scores so a simultaneous hit still counts
    if (in_round && tick_i && round_q == 16'(ROUND_TICKS - 1)) begin
      state_d    = score_tank_d == score_train_d ? ST_START : ST_WIN;
      frame_d    = score_tank_d > score_train_d ? FRAME_TANK :
                   score_tank_d < score_train_d ? FRAME_TRAIN : FRAME_START;
      bot_rst_d  = 2'b11;
      rst_cnt_d  = '0;
      tick_cnt_d = '0;
      round_d    = '0;
    end
`endif
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= ST_START;
      map_q         <= 1'b0;
      frame_q       <= FRAME_START;
      bot_rst_q     <= 2'b11;
      score_tank_q  <= '0;
      score_train_q <= '0;
      rst_cnt_q     <= '0;
      tick_cnt_q    <= '0;
`ifdef GAME_SEQ_TIMEOUT_EN
      round_q       <= '0;
`endif
    end else begin
      state_q       <= state_d;
      map_q         <= map_d;
      frame_q       <= frame_d;
      bot_rst_q     <= bot_rst_d;
      score_tank_q  <= score_tank_d;
      score_train_q <= score_train_d;
      rst_cnt_q     <= rst_cnt_d;
      tick_cnt_q    <= tick_cnt_d;
`ifdef GAME_SEQ_TIMEOUT_EN
      round_q       <= round_d;
`endif
    end
  end
  for (genvar i = 0; i < 2; i++) begin : g_fire
    fire_cooldown #(.COOLDOWN_TICKS(COOLDOWN_TICKS)) u_fire (
      .clk   (clk),
      .rstn  (rstn),
      .req   (fire_req_i[i]),
      .tick  (tick_i),
      .enable(state_q == ST_PLAY),
      .fire  (fire_o[i])
    );
  end
  assign frame_o       = frame_q;
  assign bot_rst_o     = bot_rst_q;
  assign score_tank_o  = score_tank_q;
  assign score_train_o = score_train_q;
  assign state_o       = state_q;
endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: randomized self-checking bench for game_sequencer against a score/elapsed-tick model.
// Define GAME_SEQ_TIMEOUT_EN to also exercise the round time limit.
module tb_game_sequencer;
  localparam int WIN  = 3;
  localparam int CD   = 16;
  localparam int RSP  = 8;
  localparam int HOLD = 200;
  localparam int RSTC = 4;
`ifdef GAME_SEQ_TIMEOUT_EN
  localparam int ROUND = 50;
`endif
  logic       clk = 1'b0, rstn = 1'b0, start_i = 1'b0, map_sel_i = 1'b0, tick_i = 1'b0;
  logic [1:0] fire_req_i = 2'b00, hit_i = 2'b00;
  logic [4:0] frame_o;
  logic [1:0] bot_rst_o, fire_o;
  logic [3:0] score_tank_o, score_train_o;
  logic [2:0] state_o;
  logic [19:0] snap;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  game_sequencer #(
    .WIN_SCORE(WIN), .COOLDOWN_TICKS(CD), .RESPAWN_TICKS(RSP), .WIN_HOLD_TICKS(HOLD), .RST_CYCLES(RSTC)
`ifdef GAME_SEQ_TIMEOUT_EN
    , .ROUND_TICKS(ROUND)
`endif
  ) dut (
    .clk(clk), .rstn(rstn), .start_i(start_i), .map_sel_i(map_sel_i), .tick_i(tick_i),
    .fire_req_i(fire_req_i), .hit_i(hit_i), .frame_o(frame_o), .bot_rst_o(bot_rst_o), .fire_o(fire_o),
    .score_tank_o(score_tank_o), .score_train_o(score_train_o), .state_o(state_o)
  );
  assign snap = {state_o, frame_o, bot_rst_o, fire_o, score_tank_o, score_train_o};
  function automatic logic [19:0] ex(input logic [2:0] st, input logic [4:0] fr, input logic [1:0] br,
                                     input logic [1:0] fi, input int t, input int r);
    return {st, fr, br, fi, 4'(t), 4'(r)};
  endfunction
  function automatic logic [4:0] map_frame(input logic m);
    return m ? 5'b00100 : 5'b00010;
  endfunction
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    @(negedge clk);
    {start_i, map_sel_i, tick_i, fire_req_i, hit_i} = '0;
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask
  task automatic enter_play(input logic m);
    do_reset();
    start_i = 1'b1;
    map_sel_i = m;
    cyc();
    start_i = 1'b0;
    repeat (RSTC) cyc();
  endtask
  task automatic respawn_wait();
    repeat (RSP) begin
      tick_i = 1'b1;
      cyc();
      tick_i = 1'b0;
      cyc();
    end
  endtask
  task automatic hit_and_respawn(input logic [1:0] h);
    hit_i = h;
    cyc();
    hit_i = 2'b00;
    repeat (RSTC) cyc();
    respawn_wait();
  endtask
  task automatic test_reset();
    cyc();
    checks++;
    if (snap !== ex(0, 5'b00001, 2'b11, 2'b00, 0, 0)) begin
      failures++;
      $display("FAIL reset got=%h want=%h", snap, ex(0, 5'b00001, 2'b11, 2'b00, 0, 0));
    end
    @(negedge clk);
    rstn = 1'b1;
  endtask
  task automatic test_start();
    logic [19:0] e;
    for (int m = 0; m < 2; m++) begin
      do_reset();
      start_i = 1'b1;
      map_sel_i = m[0];
      cyc();
      start_i = 1'b0;
      map_sel_i = ~m[0];
      e = ex(1, map_frame(m[0]), 2'b11, 2'b00, 0, 0);
      for (int c = 0; c < RSTC; c++) begin
        checks++;
        if (snap !== e) begin failures++; $display("FAIL arm_cycle%0d got=%h want=%h", c, snap, e); end
        if (c < RSTC - 1) cyc();
      end
      cyc();
      e = ex(2, map_frame(m[0]), 2'b00, 2'b00, 0, 0);
      checks++;
      if (snap !== e) begin failures++; $display("FAIL arm_to_play got=%h want=%h", snap, e); end
      start_i = 1'b1;
      cyc();
      start_i = 1'b0;
      cyc();
      checks++;
      if (snap !== e) begin failures++; $display("FAIL start_in_play got=%h want=%h", snap, e); end
    end
  endtask
  task automatic test_fire_random();
    int el[2];
    int nt;
    logic [1:0] exp_f;
    enter_play(1'b0);
    el = '{CD, CD};
    nt = 0;
    repeat (200) begin
      fire_req_i = 2'($urandom);
      tick_i = ($urandom_range(0, 3) == 0) && nt < 40;
      if (tick_i) nt++;
      for (int b = 0; b < 2; b++) begin
        exp_f[b] = fire_req_i[b] && el[b] >= CD;
        el[b] = exp_f[b] ? 0 : (tick_i && el[b] < CD) ? el[b] + 1 : el[b];
      end
      cyc();
      checks++;
      if (fire_o !== exp_f) begin failures++; $display("FAIL fire_random got=%b want=%b", fire_o, exp_f); end
    end
    {fire_req_i, tick_i} = '0;
  endtask
  task automatic test_fire_held();
    int shots[$];
    int want[$];
    int last, p, other;
    enter_play(1'b1);
    p = $urandom_range(2, 4);
    other = 0;
    fire_req_i = 2'b01;
    for (int k = 0; k < 40; k++)
      for (int c = 0; c < p; c++) begin
        tick_i = c == 0;
        cyc();
        if (fire_o[0]) shots.push_back(k);
        if (fire_o[1]) other++;
      end
    {fire_req_i, tick_i} = '0;
    last = -CD;
    for (int k = 0; k < 40; k++)
      if (k - last >= CD) begin want.push_back(k); last = k; end
    checks++;
    if (shots.size() != want.size()) begin
      failures++;
      $display("FAIL fire_held_count got=%0d want=%0d", shots.size(), want.size());
    end else
      for (int i = 0; i < want.size(); i++) begin
        checks++;
        if (shots[i] != want[i]) begin failures++; $display("FAIL fire_held_tick got=%0d want=%0d", shots[i], want[i]); end
      end
    checks++;
    if (other != 0) begin failures++; $display("FAIL fire_held_other got=%0d want=0", other); end
  endtask
  task automatic test_tank_win();
    logic [19:0] e;
    enter_play(1'b0);
    for (int n = 1; n <= WIN; n++) begin
      hit_i = 2'b10;
      cyc();
      hit_i = 2'b00;
      e = n < WIN ? ex(3, 5'b00010, 2'b10, 2'b00, n, 0) : ex(4, 5'b01000, 2'b11, 2'b00, n, 0);
      checks++;
      if (snap !== e) begin failures++; $display("FAIL tank_hit%0d got=%h want=%h", n, snap, e); end
      if (n < WIN) begin
        repeat (RSTC - 1) cyc();
        checks++;
        if (bot_rst_o !== 2'b10) begin failures++; $display("FAIL respawn_rst_hold got=%b want=10", bot_rst_o); end
        cyc();
        checks++;
        if (bot_rst_o !== 2'b00) begin failures++; $display("FAIL respawn_rst_end got=%b want=00", bot_rst_o); end
        respawn_wait();
        e = ex(2, 5'b00010, 2'b00, 2'b00, n, 0);
        checks++;
        if (snap !== e) begin failures++; $display("FAIL respawn_to_play got=%h want=%h", snap, e); end
      end
    end
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    hit_i = 2'b01;
    cyc();
    hit_i = 2'b00;
    e = ex(4, 5'b01000, 2'b11, 2'b00, WIN, 0);
    checks++;
    if (snap !== e) begin failures++; $display("FAIL win_ignores got=%h want=%h", snap, e); end
    tick_i = 1'b1;
    repeat (HOLD - 1) cyc();
    checks++;
    if (state_o !== 3'd4) begin failures++; $display("FAIL win_hold got=%0d want=4", state_o); end
    cyc();
    tick_i = 1'b0;
    e = ex(0, 5'b00001, 2'b11, 2'b00, WIN, 0);
    checks++;
    if (snap !== e) begin failures++; $display("FAIL win_to_start got=%h want=%h", snap, e); end
    start_i = 1'b1;
    map_sel_i = 1'b1;
    cyc();
    start_i = 1'b0;
    e = ex(1, 5'b00100, 2'b11, 2'b00, 0, 0);
    checks++;
    if (snap !== e) begin failures++; $display("FAIL restart_clear got=%h want=%h", snap, e); end
  endtask
  task automatic test_double_ko();
    logic [19:0] e;
    enter_play(1'b1);
    hit_and_respawn(2'b10);
    hit_i = 2'b11;
    cyc();
    hit_i = 2'b01;
    e = ex(3, 5'b00100, 2'b11, 2'b00, 1, 0);
    checks++;
    if (snap !== e) begin failures++; $display("FAIL double_ko got=%h want=%h", snap, e); end
    cyc();
    hit_i = 2'b00;
    checks++;
    if (snap !== e) begin failures++; $display("FAIL hit_in_respawn got=%h want=%h", snap, e); end
    fire_req_i = 2'b11;
    repeat (RSP - 1) begin
      tick_i = 1'b1;
      cyc();
      tick_i = 1'b0;
      cyc();
      checks++;
      if ({state_o, fire_o} !== 5'b011_00) begin
        failures++;
        $display("FAIL respawn_block got=%b want=01100", {state_o, fire_o});
      end
    end
    fire_req_i = 2'b00;
    tick_i = 1'b1;
    cyc();
    tick_i = 1'b0;
    e = ex(2, 5'b00100, 2'b00, 2'b00, 1, 0);
    checks++;
    if (snap !== e) begin failures++; $display("FAIL double_ko_end got=%h want=%h", snap, e); end
  endtask
  task automatic test_mid_reset();
    logic [19:0] e;
    enter_play(1'b0);
    hit_and_respawn(2'b10);
    hit_and_respawn(2'b10);
    hit_and_respawn(2'b01);
    e = ex(2, 5'b00010, 2'b00, 2'b00, 2, 1);
    checks++;
    if (snap !== e) begin failures++; $display("FAIL pre_reset got=%h want=%h", snap, e); end
    @(negedge clk);
    rstn = 1'b0;
    #2;
    e = ex(0, 5'b00001, 2'b11, 2'b00, 0, 0);
    checks++;
    if (snap !== e) begin failures++; $display("FAIL mid_reset got=%h want=%h", snap, e); end
    @(negedge clk);
    rstn = 1'b1;
    cyc();
    checks++;
    if (snap !== e) begin failures++; $display("FAIL post_reset got=%h want=%h", snap, e); end
  endtask
  task automatic test_random_match();
    logic [19:0] e;
    logic [1:0] h;
    logic m;
    int t, r;
    bit won;
    m = 1'($urandom);
    enter_play(m);
    t = 0;
    r = 0;
    won = 1'b0;
    for (int it = 0; it < 5 && !won; it++) begin
      repeat ($urandom_range(0, 3)) cyc();
      h = 2'($urandom_range(1, 3));
      hit_i = h;
      cyc();
      hit_i = 2'b00;
      if (h == 2'b10) t++;
      if (h == 2'b01) r++;
      won = t >= WIN || r >= WIN;
      e = won ? ex(4, t >= WIN ? 5'b01000 : 5'b10000, 2'b11, 2'b00, t, r) : ex(3, map_frame(m), h, 2'b00, t, r);
      checks++;
      if (snap !== e) begin failures++; $display("FAIL match_hit%0d got=%h want=%h", it, snap, e); end
      if (!won) begin
        hit_i = 2'($urandom);
        cyc();
        hit_i = 2'b00;
        repeat (RSTC - 1) cyc();
        respawn_wait();
        e = ex(2, map_frame(m), 2'b00, 2'b00, t, r);
        checks++;
        if (snap !== e) begin failures++; $display("FAIL match_play%0d got=%h want=%h", it, snap, e); end
      end
    end
  endtask
`ifdef GAME_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    logic [19:0] e;
    enter_play(1'b0);
    hit_and_respawn(2'b10);
    repeat (ROUND - RSP - 1) begin tick_i = 1'b1; cyc(); tick_i = 1'b0; cyc(); end
    checks++;
    if (state_o !== 3'd2) begin failures++; $display("FAIL timeout_early got=%0d want=2", state_o); end
    tick_i = 1'b1;
    cyc();
    tick_i = 1'b0;
    e = ex(4, 5'b01000, 2'b11, 2'b00, 1, 0);
    checks++;
    if (snap !== e) begin failures++; $display("FAIL timeout_win got=%h want=%h", snap, e); end
    enter_play(1'b1);
    repeat (ROUND - 1) begin tick_i = 1'b1; cyc(); tick_i = 1'b0; cyc(); end
    checks++;
    if (state_o !== 3'd2) begin failures++; $display("FAIL timeout_tie_early got=%0d want=2", state_o); end
    tick_i = 1'b1;
    cyc();
    tick_i = 1'b0;
    e = ex(0, 5'b00001, 2'b11, 2'b00, 0, 0);
    checks++;
    if (snap !== e) begin failures++; $display("FAIL timeout_tie got=%h want=%h", snap, e); end
  endtask
`endif
  initial begin
    #500_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_start();
    test_fire_random();
    test_fire_held();
    test_tank_win();
    test_double_ko();
    test_mid_reset();
    test_random_match();
`ifdef GAME_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
